// File: rtl/mem_responder.sv
// Load/store responder: word-organised data RAM with byte/half/word lanes plus
// an MMIO window (8N1 UART transmitter, its status, free-running cycle counter).
module mem_responder #(
  parameter int CLK_DIV   = 868,
  parameter int RAM_WORDS = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        uart_tx
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam int AW    = $clog2(RAM_WORDS);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [1:0]  r_state;
  logic        r_we;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [31:0] r_wdata;
  logic        r_err;
  logic        r_mmio;
  logic [31:0] r_mmio_q;
  logic [3:0][7:0] r_ram_q;
  logic [31:0] r_cycle;

  logic             r_busy;
  logic             r_tx;
  logic [8:0]       r_shift;
  logic [3:0]       r_bit;
  logic [DIV_W-1:0] r_div;

  logic          w_access;
  logic          w_misalign;
  logic          w_is_ram;
  logic          w_is_tx;
  logic          w_is_stat;
  logic          w_is_cyc;
  logic          w_is_mmio;
  logic          w_err;
  logic          w_ram_we;
  logic          w_tx_start;
  logic [3:0]    w_be;
  logic [31:0]   w_wlane;
  logic [31:0]   w_mmio_rd;
  logic [AW-1:0] w_idx;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load;

  // Decode works entirely on the latched request, so req_* may change freely after accept.
  always_comb begin
    w_access   = (r_state == S_ACCESS);
    w_misalign = (r_size == 2'd3) || (r_size == 2'd1 && r_addr[0]) ||
                 (r_size == 2'd2 && r_addr[1:0] != 2'b00);
    w_is_ram   = (r_addr[31:16] == 16'h0000);
    w_is_tx    = (r_addr == 32'hF000_0000);
    w_is_stat  = (r_addr == 32'hF000_0004);
    w_is_cyc   = (r_addr == 32'hF000_0008);
    w_is_mmio  = w_is_tx || w_is_stat || w_is_cyc;
    w_err      = w_misalign || !(w_is_ram || w_is_mmio) ||
                 (w_is_mmio && r_size != 2'd2) ||
                 (w_is_tx && r_we && r_busy) ||
                 ((w_is_stat || w_is_cyc) && r_we);
    w_ram_we   = w_access && w_is_ram && r_we && !w_err && !rst;
    w_tx_start = w_access && w_is_tx && r_we && !w_err;
    w_idx      = r_addr[AW+1:2];
    w_mmio_rd  = w_is_cyc ? r_cycle : (w_is_stat ? {31'd0, r_busy} : 32'd0);
    case (r_size)
      2'd0:    begin w_be = 4'b0001 << r_addr[1:0];            w_wlane = {4{r_wdata[7:0]}};  end
      2'd1:    begin w_be = r_addr[1] ? 4'b1100 : 4'b0011;     w_wlane = {2{r_wdata[15:0]}}; end
      default: begin w_be = 4'b1111;                           w_wlane = r_wdata;            end
    endcase
  end

  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && req_valid) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_size  <= req_size;
      r_uns   <= req_unsigned;
      r_wdata <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_err    <= 1'b0;
      r_mmio   <= 1'b0;
      r_mmio_q <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE:   if (req_valid) r_state <= S_ACCESS;
        S_ACCESS: begin
          r_state  <= S_RESP;
          r_err    <= w_err;
          r_mmio   <= w_is_mmio;
          r_mmio_q <= w_mmio_rd;
        end
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // One byte-wide RAM per lane gives per-byte write enables without read-modify-write.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_lane [RAM_WORDS];
      always_ff @(posedge clk) begin
        if (w_ram_we && w_be[gi]) r_lane[w_idx] <= w_wlane[8*gi +: 8];
        if (w_access)             r_ram_q[gi]   <= r_lane[w_idx];
      end
    end
  endgenerate

  always_comb begin
    w_byte = r_ram_q[r_addr[1:0]];
    w_half = r_addr[1] ? {r_ram_q[3], r_ram_q[2]} : {r_ram_q[1], r_ram_q[0]};
    case (r_size)
      2'd0:    w_load = r_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'd1:    w_load = r_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load = r_ram_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_cycle <= 32'd0;
    else     r_cycle <= r_cycle + 32'd1;
  end

  // Shift register holds the 8 data bits then the stop bit; the start bit is driven on launch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_tx    <= 1'b1;
      r_shift <= 9'h1FF;
      r_bit   <= 4'd0;
      r_div   <= '0;
    end else if (w_tx_start) begin
      r_busy  <= 1'b1;
      r_tx    <= 1'b0;
      r_shift <= {1'b1, r_wdata[7:0]};
      r_bit   <= 4'd0;
      r_div   <= DIV_LAST;
    end else if (r_busy) begin
      if (r_div == '0) begin
        r_div <= DIV_LAST;
        if (r_bit == 4'd9) begin
          r_busy <= 1'b0;
        end else begin
          r_tx    <= r_shift[0];
          r_shift <= {1'b1, r_shift[8:1]};
          r_bit   <= r_bit + 4'd1;
        end
      end else begin
        r_div <= r_div - 1'b1;
      end
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_err   = resp_valid && r_err;
  assign resp_rdata = (resp_valid && !r_err && !r_we) ? (r_mmio ? r_mmio_q : w_load) : 32'd0;
  assign uart_tx    = r_tx;

endmodule

// File: tb/tb_mem_responder.sv
// Randomised plus directed bench for mem_responder against a byte-level memory,
// UART-frame and cycle-counter reference model.
module tb_mem_responder;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        uart_tx;

  mem_responder #(.CLK_DIV(DIV), .RAM_WORDS(16384)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model state: absolute cycle tick, counter offset, UART frame start, byte memory.
  longint     m_tick = 0;
  longint     m_base = 0;
  logic [31:0] m_adj = 32'd0;
  longint     m_tx_start = -1000000;
  logic [7:0] m_tx_data = 8'd0;
  logic [7:0] m_mem [int];

  always @(posedge clk) m_tick <= m_tick + 1;

  function automatic logic m_busy(input longint c);
    return (c >= m_tx_start + 1) && (c <= m_tx_start + 10 * DIV);
  endfunction

  function automatic logic exp_tx(input longint c);
    longint d;
    logic [9:0] f;
    d = c - m_tx_start - 1;
    f = {1'b1, m_tx_data, 1'b0};
    if (d >= 0 && d < 10 * DIV) return f[int'(d / DIV)];
    return 1'b1;
  endfunction

  bit   mon_on = 1'b0;
  logic q_got[$];
  logic q_exp[$];

  always @(negedge clk) begin
    if (mon_on) begin
      q_got.push_back(uart_tx);
      q_exp.push_back(exp_tx(m_tick));
    end
  end

  task automatic drain();
    while (q_got.size() > 0) begin
      check_eq("uart_tx", 32'(q_got.pop_front()), 32'(q_exp.pop_front()));
    end
  endtask

  task automatic model_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wdata, input longint c,
                           output logic [31:0] rd, output logic er, output logic known);
    int n;
    n = 1 << size;
    rd = 32'd0; er = 1'b0; known = 1'b1;
    if (size == 2'd3 || (addr % n) != 0) begin
      er = 1'b1;
    end else if (addr <= 32'h0000_FFFF) begin
      for (int i = 0; i < n; i++) begin
        if (we) m_mem[int'(addr) + i] = 8'(wdata >> (8 * i));
        else if (!m_mem.exists(int'(addr) + i)) known = 1'b0;
        else rd = rd | (32'(m_mem[int'(addr) + i]) << (8 * i));
      end
      if (we) rd = 32'd0;
      else if (!uns && n < 4 && rd[8 * n - 1]) rd = rd | (32'hFFFF_FFFF << (8 * n));
    end else if (addr == 32'hF000_0000 || addr == 32'hF000_0004 || addr == 32'hF000_0008) begin
      if (size != 2'd2) er = 1'b1;
      else if (addr == 32'hF000_0000) begin
        if (we) begin
          if (m_busy(c)) er = 1'b1;
          else begin m_tx_start = c; m_tx_data = wdata[7:0]; end
        end
      end
      else if (we) er = 1'b1;
      else if (addr == 32'hF000_0004) rd = {31'd0, m_busy(c)};
      else rd = 32'(c - m_base) + m_adj;
    end else begin
      er = 1'b1;
    end
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic er);
    logic [31:0] e_rd;
    logic        e_er;
    logic        known;
    longint      c;
    @(negedge clk);
    check_eq("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    c = m_tick;
    model_req(we, addr, size, uns, wdata, c, e_rd, e_er, known);
    check_eq("ready_access", 32'(req_ready), 32'd0);
    check_eq("valid_access", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    check_eq("resp_valid", 32'(resp_valid), 32'd1);
    check_eq("ready_resp", 32'(req_ready), 32'd0);
    rd = resp_rdata;
    er = resp_err;
    check_eq("resp_err", 32'(er), 32'(e_er));
    if (known) check_eq("resp_rdata", rd, e_rd);
    $display("txn we=%0d addr=%h size=%0d uns=%0d wdata=%h -> rdata=%h err=%0d",
             we, addr, size, uns, wdata, rd, er);
    @(posedge clk); #1;
    check_eq("valid_after", 32'(resp_valid), 32'd0);
    drain();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] rd_v;
  logic        er_v;
  logic [31:0] v1;
  logic [31:0] v2;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    m_base = m_tick;
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    check_eq("rst_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_rdata", resp_rdata, 32'd0);
    check_eq("rst_err", 32'(resp_err), 32'd0);
    check_eq("rst_uart", 32'(uart_tx), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    mon_on = 1'b1;

    do_req(1'b1, 32'h100, 2'd2, 1'b0, 32'hDEAD_BEEF, rd_v, er_v);
    do_req(1'b0, 32'h100, 2'd2, 1'b0, 32'd0, rd_v, er_v);
    check_eq("lw_beef", rd_v, 32'hDEAD_BEEF);
    do_req(1'b1, 32'h103, 2'd0, 1'b0, 32'h0000_0080, rd_v, er_v);
    do_req(1'b0, 32'h103, 2'd0, 1'b0, 32'd0, rd_v, er_v);
    check_eq("lb_sext", rd_v, 32'hFFFF_FF80);
    do_req(1'b0, 32'h103, 2'd0, 1'b1, 32'd0, rd_v, er_v);
    check_eq("lbu_zext", rd_v, 32'h0000_0080);
    do_req(1'b0, 32'h100, 2'd2, 1'b0, 32'd0, rd_v, er_v);
    check_eq("lw_merge", rd_v, 32'h80AD_BEEF);

    do_req(1'b0, 32'h101, 2'd1, 1'b0, 32'd0, rd_v, er_v);
    check_eq("lh_mis_err", 32'(er_v), 32'd1);
    do_req(1'b0, 32'h102, 2'd2, 1'b0, 32'd0, rd_v, er_v);
    check_eq("lw_mis_err", 32'(er_v), 32'd1);
    do_req(1'b0, 32'h0001_0000, 2'd2, 1'b0, 32'd0, rd_v, er_v);
    check_eq("lw_oor_err", 32'(er_v), 32'd1);
    do_req(1'b1, 32'hF000_0000, 2'd0, 1'b0, 32'h55, rd_v, er_v);
    check_eq("sb_mmio_err", 32'(er_v), 32'd1);
    do_req(1'b1, 32'h100, 2'd3, 1'b0, 32'h1234_5678, rd_v, er_v);
    do_req(1'b0, 32'h100, 2'd2, 1'b0, 32'd0, rd_v, er_v);
    check_eq("ram_unchanged", rd_v, 32'h80AD_BEEF);

    // Preload the random window and the top RAM word, then random traffic.
    for (int i = 0; i < 16; i++) begin
      do_req(1'b1, 32'h100 + 32'(4 * i), 2'd2, 1'b0, $urandom, rd_v, er_v);
    end
    do_req(1'b1, 32'hFFFC, 2'd2, 1'b0, $urandom, rd_v, er_v);
    for (int i = 0; i < 150; i++) begin
      int r;
      logic [31:0] a;
      logic w;
      logic [1:0] sz;
      r  = int'($urandom_range(0, 19));
      sz = 2'($urandom_range(0, 3));
      w  = 1'($urandom_range(0, 1));
      if (r < 13)       a = 32'h100 + 32'($urandom_range(0, 63));
      else if (r == 13) a = 32'h0001_0000 + 32'($urandom_range(0, 255));
      else if (r == 14) a = 32'hF000_0004;
      else if (r == 15) a = 32'hF000_0008;
      else if (r == 16) a = 32'hF000_000C;
      else if (r == 17) a = 32'hFFFC + 32'($urandom_range(0, 3));
      else begin a = 32'hF000_0000; w = 1'b0; end
      if (r >= 14 && r <= 16 && $urandom_range(0, 1) == 1) sz = 2'd2;
      do_req(w, a, sz, 1'($urandom_range(0, 1)), $urandom, rd_v, er_v);
    end

    // UART frame, mid-frame status/rejection, and the stop-bit-end boundary.
    do_req(1'b1, 32'hF000_0000, 2'd2, 1'b0, 32'h0000_00A5, rd_v, er_v);
    check_eq("tx_accept", 32'(er_v), 32'd0);
    do_req(1'b0, 32'hF000_0004, 2'd2, 1'b0, 32'd0, rd_v, er_v);
    check_eq("stat_busy", rd_v, 32'd1);
    do_req(1'b1, 32'hF000_0000, 2'd2, 1'b0, 32'h0000_005A, rd_v, er_v);
    check_eq("tx_busy_err", 32'(er_v), 32'd1);
    repeat (40) @(negedge clk);
    do_req(1'b0, 32'hF000_0004, 2'd2, 1'b0, 32'd0, rd_v, er_v);
    check_eq("stat_idle", rd_v, 32'd0);
    do_req(1'b1, 32'hF000_0000, 2'd2, 1'b0, 32'h0000_00C3, rd_v, er_v);
    repeat (37) @(negedge clk);
    do_req(1'b0, 32'hF000_0004, 2'd2, 1'b0, 32'd0, rd_v, er_v);
    check_eq("stat_edge", rd_v, 32'd1);
    do_req(1'b1, 32'hF000_0000, 2'd2, 1'b0, 32'h0000_003C, rd_v, er_v);
    repeat (37) @(negedge clk);
    do_req(1'b1, 32'hF000_0000, 2'd2, 1'b0, 32'h0000_0011, rd_v, er_v);
    check_eq("tx_edge_err", 32'(er_v), 32'd1);
    repeat (45) @(negedge clk);
    drain();

    do_req(1'b0, 32'hF000_0008, 2'd2, 1'b0, 32'd0, v1, er_v);
    repeat (7) @(negedge clk);
    do_req(1'b0, 32'hF000_0008, 2'd2, 1'b0, 32'd0, v2, er_v);
    check_eq("cyc_delta", v2 - v1, 32'd10);

    @(negedge clk);
    force dut.r_cycle = 32'hFFFF_FFFE;
    release dut.r_cycle;
    m_adj = 32'hFFFF_FFFE - 32'(m_tick - m_base);
    @(negedge clk);
    do_req(1'b0, 32'hF000_0008, 2'd2, 1'b0, 32'd0, rd_v, er_v);
    check_eq("cyc_wrap", rd_v, 32'h0000_0001);

    // Reset during a load's ACCESS cycle while a UART frame is in flight.
    do_req(1'b1, 32'hF000_0000, 2'd2, 1'b0, 32'h0000_00F0, rd_v, er_v);
    repeat (10) @(negedge clk);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100; req_size = 2'd2; req_unsigned = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    m_base = m_tick;
    m_adj = 32'd0;
    m_tx_start = -1000000;
    check_eq("rstmid_valid", 32'(resp_valid), 32'd0);
    check_eq("rstmid_ready", 32'(req_ready), 32'd1);
    check_eq("rstmid_uart", 32'(uart_tx), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rstmid_novalid", 32'(resp_valid), 32'd0);
    do_req(1'b0, 32'h100, 2'd2, 1'b0, 32'd0, rd_v, er_v);
    do_req(1'b0, 32'hF000_0008, 2'd2, 1'b0, 32'd0, rd_v, er_v);
    repeat (5) @(negedge clk);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
